dram_req_sched: RTL and testbench
=================================

Name: dram_req_sched

Overview:
- Upstream front-end for the DRAM RAS/MUX/CAS timing generator.
- Accepts single-beat read/write requests from one client over a valid/ready handshake, with an internal periodic refresh source.
- Issues a one-cycle req pulse to the timing generator and steers row/column address using the generator's mux output.
- Drives DRAM write enable and data-out, captures read data, and returns a one-cycle response.

Parameters:
- ADDR_W, 8, row width and column width (equal); request address is 2*ADDR_W bits, {row, col}.
- DATA_W, 8, DRAM data width.
- REFRESH_PERIOD, 256, clk cycles between refresh requests; must be ≥ 16.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  client request valid.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  2*ADDR_W  {row, col}.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse when a client access completes.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid on reads, held otherwise.
- tg_req  out  1  one-cycle start pulse to the timing generator.
- tg_ras_n  in  1  generator RAS, active-low; high = generator idle.
- tg_mux  in  1  generator address select: 0 = row, 1 = column.
- tg_cas_n  in  1  generator CAS, active-low.
- dram_addr  out  ADDR_W  latched row when tg_mux=0, latched column when tg_mux=1 (combinational mux).
- dram_we_n  out  1  active-low write enable.
- dram_dq_out  out  DATA_W  latched write data.
- dram_dq_oe  out  1  data output enable.
- dram_dq_in  in  DATA_W  read data from DRAM.

Behaviour:
- Reset values:
  - state IDLE; tg_req=0; rsp_valid=0; rsp_rdata=0.
  - Latched row/col/wdata/we = 0; dram_we_n=1; dram_dq_oe=0.
  - Refresh counter=0, refresh row=0, refresh_pending=0.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - req_ready = (state==IDLE) && !refresh_pending && tg_ras_n.
  - If refresh_pending && tg_ras_n: latch row=refresh row, col=0, we=0, mark access as refresh, clear refresh_pending, go to ISSUE.
  - Else if req_valid && req_ready: latch addr/we/wdata, go to ISSUE.
  - Refresh has priority over a simultaneous client request.
- ISSUE: tg_req=1 for exactly this cycle; go to BUSY.
- BUSY:
  - Register previous tg_ras_n. On the cycle tg_ras_n is high after having been low in this state, leave BUSY.
  - Client access goes to RESP; refresh goes to IDLE.
  - While tg_cas_n=0 on a read, capture dram_dq_in into rsp_rdata every cycle; the last CAS-low sample is kept.
- RESP: rsp_valid=1 for one cycle; go to IDLE.
- Writes: dram_we_n=0 and dram_dq_oe=1 throughout ISSUE and BUSY. Otherwise dram_we_n=1 and dram_dq_oe=0.
- Nominal latency, client read or write:
  - Handshake at cycle 0; tg_req at cycle 1.
  - RAS low cycles 2–5; CAS low cycles 4–5.
  - rsp_valid at cycle 7.
  - Next request accepted at cycle 8 at the earliest.
- Refresh:
  - Free-running counter 0..REFRESH_PERIOD-1; at terminal count it sets refresh_pending and wraps.
  - Expiry while already pending is not queued; the flag stays 1.
  - Refresh row increments by one after each issued refresh and wraps at 2^ADDR_W.
  - A refresh is a dummy read of {refresh row, col 0}; it produces no rsp_valid and does not change rsp_rdata.
- Reset mid-access:
  - All outputs return to reset values immediately.
  - The generator has no reset and may finish its sequence. tg_ras_n gating of req_ready and refresh issue prevents overlap.

Optional Feature:
- Macro: DRAM_REFRESH_EN.
- Defined: refresh counter, refresh row, pending flag and refresh priority as above.
- Undefined: no refresh logic; refresh_pending is constant 0; only client accesses are issued; REFRESH_PERIOD is unused.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, ISSUE=1, BUSY=2, RESP=3).
  - Default ADDR_W/DATA_W constants.
  - Generator cycle count (5) for bench checking.
- Sub-module dram_refresh_timer (counter, pending flag, row counter) is natural and is instantiated only under DRAM_REFRESH_EN.

Test Plan:
- Single read, addr=16'h3A5C, dq_in=8'hC3 during CAS-low: tg_req at cycle 1; dram_addr=8'h3A while tg_mux=0 and 8'h5C while tg_mux=1; rsp_valid at cycle 7 with rsp_rdata=8'hC3.
- Single write, addr=16'h0102, wdata=8'h55: dram_we_n=0, dram_dq_oe=1, dram_dq_out=8'h55 from cycle 1 until BUSY exits; rsp_valid at cycle 7; rsp_rdata unchanged.
- Back-to-back req_valid held high: req_ready=0 cycles 1–7; second handshake no earlier than cycle 8; exactly one tg_req pulse per access.
- DRAM_REFRESH_EN, REFRESH_PERIOD=16, req_valid=1 asserted the same cycle refresh_pending rises: refresh issued first with dram_addr row=0, no rsp_valid; client access follows; the next refresh uses row 1.
- reset_n pulsed low during BUSY with the generator still running: outputs at reset values immediately; after release, req_ready stays 0 until tg_ras_n=1.
- Without DRAM_REFRESH_EN, 1000 idle cycles: tg_req never asserts.

Source files
------------

// File: rtl/dram_req_sched_pkg.sv
// Shared types and constants for the DRAM request scheduler and its bench.
// Optional refresh logic is selected with the DRAM_REFRESH_EN macro.
package dram_req_sched_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Cycles from tg_req to the generator raising RAS again.
    localparam int GEN_CYCLES = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/dram_req_sched_if.sv
// Client-side request/response bundle for dram_req_sched.
// The master modport is the client; the slave modport is the scheduler.
interface dram_req_sched_if
    import dram_req_sched_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2*ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/dram_req_sched_refresh_timer.sv
// Periodic refresh source: free-running period counter, sticky pending flag
// and refresh row counter. Only instantiated when DRAM_REFRESH_EN is defined.
module dram_refresh_timer
    import dram_req_sched_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int REFRESH_PERIOD = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              refresh_taken,
    output logic              refresh_pending,
    output logic [ADDR_W-1:0] refresh_row
);

    localparam int CNT_W = $clog2(REFRESH_PERIOD);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(REFRESH_PERIOD - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] row_q, row_d;

    always_comb begin
        cnt_d     = (cnt_q == CNT_TC) ? '0 : cnt_q + 1'b1;
        pending_d = pending_q;
        row_d     = row_q;
        if (refresh_taken) begin
            pending_d = 1'b0;
            row_d     = row_q + 1'b1;
        end
        // A fresh expiry wins over a same-cycle take; expiries never queue.
        if (cnt_q == CNT_TC) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            row_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            row_q     <= row_d;
        end
    end

    assign refresh_pending = pending_q;
    assign refresh_row     = row_q;

endmodule

// File: rtl/dram_req_sched.sv
// Front-end for the DRAM RAS/MUX/CAS timing generator: client requests,
// address steering, write drive and read capture. Refresh via DRAM_REFRESH_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting; accepts a client request or starts a refresh
// ST_ISSUE | one-cycle tg_req pulse to the timing generator
// ST_BUSY  | generator running; read data captured while CAS is low
// ST_RESP  | one-cycle rsp_valid to the client (not for refresh)
module dram_req_sched
    import dram_req_sched_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int REFRESH_PERIOD = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    dram_req_sched_if.slave   bus,
    output logic              tg_req,
    input  logic              tg_ras_n,
    input  logic              tg_mux,
    input  logic              tg_cas_n,
    output logic [ADDR_W-1:0] dram_addr,
    output logic              dram_we_n,
    output logic [DATA_W-1:0] dram_dq_out,
    output logic              dram_dq_oe,
    input  logic [DATA_W-1:0] dram_dq_in
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              is_ref_q, is_ref_d;
    logic              ras_prev_q, ras_prev_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              refresh_pending;
    logic [ADDR_W-1:0] refresh_row;
    logic              start_refresh;
    logic              req_ready;

    assign start_refresh = (state_q == ST_IDLE) && refresh_pending && tg_ras_n;

`ifdef DRAM_REFRESH_EN
    dram_refresh_timer #(
        .ADDR_W         (ADDR_W),
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk             (clk),
        .reset_n         (reset_n),
        .refresh_taken   (start_refresh),
        .refresh_pending (refresh_pending),
        .refresh_row     (refresh_row)
    );
`else
    localparam int refresh_period_unused = REFRESH_PERIOD;
    assign refresh_pending = 1'b0;
    assign refresh_row     = '0;
`endif

    // The generator is not reset, so RAS high gates every new start.
    assign req_ready = (state_q == ST_IDLE) && !refresh_pending && tg_ras_n;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        is_ref_d   = is_ref_q;
        rdata_d    = rdata_q;
        ras_prev_d = tg_ras_n;

        case (state_q)
            ST_IDLE: begin
                if (start_refresh) begin
                    row_d    = refresh_row;
                    col_d    = '0;
                    we_d     = 1'b0;
                    is_ref_d = 1'b1;
                    state_d  = ST_ISSUE;
                end else if (bus.req_valid && req_ready) begin
                    row_d    = bus.req_addr[2*ADDR_W-1:ADDR_W];
                    col_d    = bus.req_addr[ADDR_W-1:0];
                    wdata_d  = bus.req_wdata;
                    we_d     = bus.req_we;
                    is_ref_d = 1'b0;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (!tg_cas_n && !we_q && !is_ref_q) begin
                    rdata_d = dram_dq_in;
                end
                if (tg_ras_n && !ras_prev_q) begin
                    state_d = is_ref_q ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            is_ref_q   <= 1'b0;
            ras_prev_q <= 1'b1;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            is_ref_q   <= is_ref_d;
            ras_prev_q <= ras_prev_d;
            rdata_q    <= rdata_d;
        end
    end

    assign tg_req        = (state_q == ST_ISSUE);
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;

    assign dram_addr   = tg_mux ? col_q : row_q;
    assign dram_dq_out = wdata_q;
    assign dram_dq_oe  = we_q && ((state_q == ST_ISSUE) || (state_q == ST_BUSY));
    assign dram_we_n   = !dram_dq_oe;

endmodule

// File: tb/tb_dram_req_sched.sv
// Directed bench for dram_req_sched with a behavioural timing generator.
// Define DRAM_REFRESH_EN to run the refresh-priority sequence instead.
module tb_dram_req_sched;
    import dram_req_sched_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tg_req;
    logic          tg_ras_n;
    logic          tg_mux;
    logic          tg_cas_n;
    logic [AW-1:0] dram_addr;
    logic          dram_we_n;
    logic [DW-1:0] dram_dq_out;
    logic          dram_dq_oe;
    logic [DW-1:0] dram_dq_in;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_tg = 0;
    int            n_rsp = 0;
    int            gen_cnt = 0;
    logic [DW-1:0] cas_data = 8'hC3;

    always #5 clk = ~clk;

    dram_req_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dram_req_sched #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .REFRESH_PERIOD (16)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .tg_req      (tg_req),
        .tg_ras_n    (tg_ras_n),
        .tg_mux      (tg_mux),
        .tg_cas_n    (tg_cas_n),
        .dram_addr   (dram_addr),
        .dram_we_n   (dram_we_n),
        .dram_dq_out (dram_dq_out),
        .dram_dq_oe  (dram_dq_oe),
        .dram_dq_in  (dram_dq_in)
    );

    // Generator model: RAS low 4 cycles after tg_req, mux 3, CAS 2; no reset.
    always @(posedge clk) begin
        if (gen_cnt == 0) begin
            if (tg_req) gen_cnt <= 1;
        end else if (gen_cnt == GEN_CYCLES - 1) begin
            gen_cnt <= 0;
        end else begin
            gen_cnt <= gen_cnt + 1;
        end
    end

    assign tg_ras_n   = (gen_cnt == 0);
    assign tg_mux     = (gen_cnt >= 2);
    assign tg_cas_n   = !(gen_cnt >= 3);
    assign dram_dq_in = tg_cas_n ? 8'hEE : cas_data;

    always @(negedge clk) begin
        if (tg_req)        n_tg  <= n_tg + 1;
        if (bus.rsp_valid) n_rsp <= n_rsp + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tg0;
        int rsp0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tg_req",   tg_req,        1'b0);
        chk("rst_rsp_vld",  bus.rsp_valid, 1'b0);
        chk("rst_rdata",    bus.rsp_rdata, 8'h00);
        chk("rst_we_n",     dram_we_n,     1'b1);
        chk("rst_oe",       dram_dq_oe,    1'b0);
        chk("rst_dq_out",   dram_dq_out,   8'h00);
        chk("rst_addr",     dram_addr,     8'h00);
        chk("rst_ready",    bus.req_ready, 1'b1);
        cyc();
        reset_n = 1'b1;

`ifdef DRAM_REFRESH_EN
        cas_data = 8'h5A;
        for (int c = 0; c <= 34; c++) begin
            if (c == 16) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b0;
                bus.req_addr  = 16'h4455;
            end
            if (c == 24) bus.req_valid = 1'b0;
            @(negedge clk);
            case (c)
                15: chk("ref_ready_before", bus.req_ready, 1'b1);
                16: chk("ref_ready_pending", bus.req_ready, 1'b0);
                17: begin
                    chk("ref0_tg_req", tg_req, 1'b1);
                    chk("ref0_row", dram_addr, 8'h00);
                end
                23: begin
                    chk("ref_client_ready", bus.req_ready, 1'b1);
                    chk("ref_rdata_kept", bus.rsp_rdata, 8'h00);
                    chk("ref_no_rsp", n_rsp, 0);
                end
                24: begin
                    chk("ref_cli_tg_req", tg_req, 1'b1);
                    chk("ref_cli_row", dram_addr, 8'h44);
                end
                26: chk("ref_cli_col", dram_addr, 8'h55);
                30: begin
                    chk("ref_cli_rsp", bus.rsp_valid, 1'b1);
                    chk("ref_cli_rdata", bus.rsp_rdata, 8'h5A);
                end
                33: begin
                    chk("ref1_tg_req", tg_req, 1'b1);
                    chk("ref1_row", dram_addr, 8'h01);
                end
                default: ;
            endcase
            cyc();
        end
        chk("ref_rsp_count", n_rsp, 1);
        chk("ref_tg_count", n_tg, 3);
`else
        // Single read of 0x3A5C.
        cyc();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h3A5C;
        @(negedge clk);
        chk("rd_ready", bus.req_ready, 1'b1);
        cyc();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rd_tg_req", tg_req, 1'b1);
        chk("rd_row_c1", dram_addr, 8'h3A);
        chk("rd_ready_busy", bus.req_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk("rd_tg_req_once", tg_req, 1'b0);
        chk("rd_row_c2", dram_addr, 8'h3A);
        cyc();
        @(negedge clk);
        chk("rd_col_c3", dram_addr, 8'h5C);
        repeat (3) cyc();
        @(negedge clk);
        chk("rd_no_rsp_c6", bus.rsp_valid, 1'b0);
        cyc();
        @(negedge clk);
        chk("rd_rsp_c7", bus.rsp_valid, 1'b1);
        chk("rd_rdata", bus.rsp_rdata, 8'hC3);

        // Single write of 0x55 to 0x0102, handshake at the first free cycle.
        cyc();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h0102;
        bus.req_wdata = 8'h55;
        @(negedge clk);
        chk("wr_rsp_drop", bus.rsp_valid, 1'b0);
        chk("wr_ready_c8", bus.req_ready, 1'b1);
        chk("wr_we_n_idle", dram_we_n, 1'b1);
        cyc();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("wr_tg_req", tg_req, 1'b1);
        chk("wr_we_n_c1", dram_we_n, 1'b0);
        chk("wr_oe_c1", dram_dq_oe, 1'b1);
        chk("wr_dq_out", dram_dq_out, 8'h55);
        chk("wr_row", dram_addr, 8'h01);
        for (int i = 2; i <= 6; i++) begin
            cyc();
            @(negedge clk);
            chk("wr_we_n_busy", dram_we_n, 1'b0);
            chk("wr_oe_busy", dram_dq_oe, 1'b1);
            if (i == 3) chk("wr_col", dram_addr, 8'h02);
        end
        cyc();
        @(negedge clk);
        chk("wr_rsp_c7", bus.rsp_valid, 1'b1);
        chk("wr_we_n_resp", dram_we_n, 1'b1);
        chk("wr_oe_resp", dram_dq_oe, 1'b0);
        chk("wr_rdata_kept", bus.rsp_rdata, 8'hC3);

        // Back-to-back reads with req_valid held high.
        cyc();
        cas_data      = 8'h7E;
        tg0           = n_tg;
        rsp0          = n_rsp;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h1234;
        @(negedge clk);
        chk("b2b_ready_c0", bus.req_ready, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            cyc();
            @(negedge clk);
            chk("b2b_ready_busy", bus.req_ready, 1'b0);
        end
        cyc();
        @(negedge clk);
        chk("b2b_ready_c8", bus.req_ready, 1'b1);
        cyc();
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_tg_req_c9", tg_req, 1'b1);
        repeat (6) cyc();
        @(negedge clk);
        chk("b2b_rsp_c15", bus.rsp_valid, 1'b1);
        chk("b2b_rdata", bus.rsp_rdata, 8'h7E);
        cyc();
        chk("b2b_tg_pulses", n_tg - tg0, 2);
        chk("b2b_rsp_pulses", n_rsp - rsp0, 2);

        // Reset pulse in the middle of a write while the generator runs.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 16'h00FF;
        bus.req_wdata = 8'hAA;
        cyc();
        bus.req_valid = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("mid_we_n_busy", dram_we_n, 1'b0);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_tg_req", tg_req, 1'b0);
        chk("mid_rst_we_n", dram_we_n, 1'b1);
        chk("mid_rst_oe", dram_dq_oe, 1'b0);
        chk("mid_rst_dq_out", dram_dq_out, 8'h00);
        chk("mid_rst_rdata", bus.rsp_rdata, 8'h00);
        chk("mid_rst_rsp", bus.rsp_valid, 1'b0);
        chk("mid_rst_ready", bus.req_ready, 1'b0);
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_ready_c4", bus.req_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk("mid_ready_c5", bus.req_ready, 1'b0);
        chk("mid_no_tg_req", tg_req, 1'b0);
        cyc();
        @(negedge clk);
        chk("mid_ready_c6", bus.req_ready, 1'b1);

        // Long idle stretch: no refresh source in this build.
        cyc();
        tg0 = n_tg;
        repeat (1000) cyc();
        chk("idle_no_tg_req", n_tg - tg0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
